mem_port_sequencer: RTL and testbench

Arbitrates and sequences the core's single 32-bit memory port between the instruction-fetch path and the load/store path. It performs RV32I byte-lane formatting:
- store strobes and replication for SB/SH/SW;
- load extraction with sign or zero extension for LB/LH/LW/LBU/LHU.

It checks alignment and runs a valid/ready bus transaction with a timeout watchdog. It sits between the decoder's memory controls (enable, read/write mode, funct3) plus ALU address, and the external memory.

---
 rtl/mem_port_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_port_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sequencer.sv
// Shares one 32-bit memory port between instruction fetch and load/store,
// with RV32I byte-lane formatting, alignment checks and a bus timeout watchdog.
module mem_port_sequencer #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUS_IF = 2'd1, ST_BUS_D = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             last_d_q, last_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       func_q, func_d;
  logic [1:0]       off_q, off_d;
  logic             bus_valid_q, bus_valid_d, bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]       bus_wstrb_q, bus_wstrb_d;
  logic             if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic [31:0]      if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic             d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic             busy_q, busy_d;

  logic        if_req_m, d_req_m, grant_data, d_illegal;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_if_addr_bits;

  assign unused_if_addr_bits = ^if_addr[1:0];

  // A requester acked this cycle is ignored so its stale req is not re-granted.
  assign if_req_m   = if_req & ~if_ack_q;
  assign d_req_m    = d_req & ~d_ack_q;
  assign grant_data = d_req_m & (~if_req_m | ~last_d_q);

  always_comb begin
    if (d_we) d_illegal = d_func[2] || (d_func == 3'b011);
    else      d_illegal = (d_func == 3'b011) || (d_func == 3'b110) || (d_func == 3'b111);
    if (d_func[1:0] == 2'b01 && d_addr[0])          d_illegal = 1'b1;
    if (d_func[1:0] == 2'b10 && d_addr[1:0] != 2'b00) d_illegal = 1'b1;
  end

  // Store lane strobes and replicated write data.
  always_comb begin
    st_strb  = 4'b0000;
    st_wdata = d_wdata;
    case (d_func)
      3'b000: begin
        st_strb  = 4'b0001 << d_addr[1:0];
        st_wdata = {4{d_wdata[7:0]}};
      end
      3'b001: begin
        st_strb  = d_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{d_wdata[15:0]}};
      end
      3'b010:  st_strb = 4'b1111;
      default: st_strb = 4'b0000;
    endcase
  end

  // Load lane extraction and extension, using the offset/funct3 captured at grant.
  always_comb begin
    ld_byte = bus_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (func_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_val = bus_rdata;
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    func_d      = func_q;
    off_d       = off_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = 32'h0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          last_d_d = 1'b1;
          if (d_illegal) begin
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end else begin
            state_d     = ST_BUS_D;
            cnt_d       = '0;
            func_d      = d_func;
            off_d       = d_addr[1:0];
            bus_valid_d = 1'b1;
            bus_we_d    = d_we;
            bus_addr_d  = {d_addr[31:2], 2'b00};
            bus_wstrb_d = d_we ? st_strb : 4'b0000;
            bus_wdata_d = d_we ? st_wdata : 32'h0;
          end
        end else if (if_req_m) begin
          last_d_d    = 1'b0;
          state_d     = ST_BUS_IF;
          cnt_d       = '0;
          bus_valid_d = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = {if_addr[31:2], 2'b00};
          bus_wstrb_d = 4'b0000;
          bus_wdata_d = 32'h0;
        end
      end
      ST_BUS_IF, ST_BUS_D: begin
        if (bus_ready || cnt_q == WAIT_LAST) begin
          state_d     = ST_IDLE;
          bus_valid_d = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = 32'h0;
          bus_wstrb_d = 4'b0000;
          bus_wdata_d = 32'h0;
          if (state_q == ST_BUS_IF) begin
            if_ack_d   = 1'b1;
            if_err_d   = ~bus_ready;
            if_rdata_d = bus_ready ? bus_rdata : 32'h0;
          end else begin
            d_ack_d   = 1'b1;
            d_err_d   = ~bus_ready;
            d_rdata_d = (bus_ready && !bus_we_q) ? ld_val : 32'h0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_d_q    <= 1'b1;
      cnt_q       <= '0;
      func_q      <= 3'b000;
      off_q       <= 2'b00;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wstrb_q <= 4'b0000;
      bus_wdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= 32'h0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
      func_q      <= func_d;
      off_q       <= off_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      if_ack_q    <= if_ack_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: vector table, directed multi-cycle sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_sequencer;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst, if_req, d_req, d_we, bus_ready;
  logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
  logic [2:0]  d_func;
  logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
  logic        if_ack, if_err, d_ack, d_err, bus_valid, bus_we, busy;
  logic [3:0]  bus_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_func(d_func), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        ill;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " bus_valid"}, 32'(bus_valid), 32'h0);
    chk({tag, " bus_we"},    32'(bus_we),    32'h0);
    chk({tag, " bus_addr"},  bus_addr,       32'h0);
    chk({tag, " bus_wstrb"}, 32'(bus_wstrb), 32'h0);
    chk({tag, " bus_wdata"}, bus_wdata,      32'h0);
    chk({tag, " if_ack"},    32'(if_ack),    32'h0);
    chk({tag, " if_err"},    32'(if_err),    32'h0);
    chk({tag, " if_rdata"},  if_rdata,       32'h0);
    chk({tag, " d_ack"},     32'(d_ack),     32'h0);
    chk({tag, " d_err"},     32'(d_err),     32'h0);
    chk({tag, " d_rdata"},   d_rdata,        32'h0);
    chk({tag, " busy"},      32'(busy),      32'h0);
  endtask

  // Reference formatting from the RV32I rules, with plain arithmetic.
  function automatic bit ref_illegal(input bit we, input logic [2:0] f, input logic [31:0] a);
    int fi  = int'(f);
    int off = int'(a[1:0]);
    int sz;
    if (we && fi > 2) return 1'b1;
    if (!we && (fi == 3 || fi > 5)) return 1'b1;
    sz = 1 << (fi % 4);
    return (off % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] w = r >> (8 * int'(a[1:0]));
    logic [31:0] b = w & 32'hFF;
    logic [31:0] h = w & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd2:    return r;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f, input logic [31:0] a);
    int off = int'(a[1:0]);
    case (f)
      3'd0:    return 4'(1 << off);
      3'd1:    return (off >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f, input logic [31:0] d);
    case (f)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; bus_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v = vt[i];
    string t = $sformatf("vec%0d", i);
    d_req = 1'b1; d_we = v.we; d_func = v.func; d_addr = v.addr; d_wdata = v.wdata;
    step();
    if (v.ill) begin
      chk({t, " bus_valid"}, 32'(bus_valid), 32'h0);
      chk({t, " busy"},      32'(busy),      32'h0);
      chk({t, " d_ack"},     32'(d_ack),     32'h1);
      chk({t, " d_err"},     32'(d_err),     32'h1);
      chk({t, " d_rdata"},   d_rdata,        32'h0);
    end else begin
      for (int k = 0; k <= v.delay; k++) begin
        chk({t, " bus_valid"}, 32'(bus_valid), 32'h1);
        chk({t, " bus_addr"},  bus_addr,       v.e_addr);
        chk({t, " bus_we"},    32'(bus_we),    32'(v.we));
        chk({t, " bus_wstrb"}, 32'(bus_wstrb), 32'(v.e_strb));
        if (v.we) chk({t, " bus_wdata"}, bus_wdata, v.e_wdata);
        chk({t, " busy"},      32'(busy),      32'h1);
        chk({t, " early d_ack"}, 32'(d_ack),   32'h0);
        if (k == v.delay) begin bus_ready = 1'b1; bus_rdata = v.rdata; end
        step();
      end
      bus_ready = 1'b0;
      chk({t, " d_ack"},     32'(d_ack),     32'h1);
      chk({t, " d_err"},     32'(d_err),     32'h0);
      chk({t, " d_rdata"},   d_rdata,        v.e_rdata);
      chk({t, " bus_valid"}, 32'(bus_valid), 32'h0);
      chk({t, " busy"},      32'(busy),      32'h0);
    end
    d_req = 1'b0;
    step();
    chk({t, " d_ack once"}, 32'(d_ack), 32'h0);
    chk({t, " idle valid"}, 32'(bus_valid), 32'h0);
  endtask

  task automatic run_random(input int ncyc);
    int owner, g;
    bit last_data, ifr, dr, dwe, rdy, el_if, el_d;
    logic [2:0]  dfn;
    logic [31:0] ifa, dad, dwd, rdat;
    bit e_valid, e_we, e_busy, e_ifack, e_iferr, e_dack, e_derr;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_wdata, e_ifrd, e_drd;
    bit n_valid, n_we, n_busy, n_ifack, n_iferr, n_dack, n_derr;
    logic [3:0]  n_strb;
    logic [31:0] n_addr, n_wdata, n_ifrd, n_drd;

    owner = 0; g = 0; last_data = 1'b1; ifr = 1'b0; dr = 1'b0; dwe = 1'b0;
    dfn = 3'd0; ifa = 32'h0; dad = 32'h0; dwd = 32'h0;
    e_valid = 0; e_we = 0; e_busy = 0; e_ifack = 0; e_iferr = 0; e_dack = 0; e_derr = 0;
    e_strb = 4'h0; e_addr = 32'h0; e_wdata = 32'h0; e_ifrd = 32'h0; e_drd = 32'h0;

    for (int c = 0; c < ncyc; c++) begin
      chk("rnd bus_valid", 32'(bus_valid), 32'(e_valid));
      chk("rnd busy",      32'(busy),      32'(e_busy));
      chk("rnd if_ack",    32'(if_ack),    32'(e_ifack));
      chk("rnd if_err",    32'(if_err),    32'(e_iferr));
      chk("rnd d_ack",     32'(d_ack),     32'(e_dack));
      chk("rnd d_err",     32'(d_err),     32'(e_derr));
      if (e_ifack) chk("rnd if_rdata", if_rdata, e_ifrd);
      if (e_dack)  chk("rnd d_rdata",  d_rdata,  e_drd);
      if (e_valid) begin
        chk("rnd bus_addr",  bus_addr,       e_addr);
        chk("rnd bus_we",    32'(bus_we),    32'(e_we));
        chk("rnd bus_wstrb", 32'(bus_wstrb), 32'(e_strb));
        if (e_we) chk("rnd bus_wdata", bus_wdata, e_wdata);
      end

      if (e_ifack) ifr = 1'b0;
      if (e_dack)  dr  = 1'b0;
      if (!ifr && $urandom_range(0, 2) == 0) begin ifr = 1'b1; ifa = $urandom; end
      if (!dr && $urandom_range(0, 2) == 0) begin
        dr = 1'b1; dwe = 1'($urandom_range(0, 1)); dfn = 3'($urandom_range(0, 7));
        dad = $urandom & 32'h0000_0FFF; dwd = $urandom;
      end
      rdy  = ($urandom_range(0, 3) == 0);
      rdat = $urandom;
      if_req = ifr; if_addr = ifa;
      d_req = dr; d_we = dwe; d_func = dfn; d_addr = dad; d_wdata = dwd;
      bus_ready = rdy; bus_rdata = rdat;

      n_valid = 0; n_we = 0; n_busy = 0; n_ifack = 0; n_iferr = 0; n_dack = 0; n_derr = 0;
      n_strb = 4'h0; n_addr = 32'h0; n_wdata = 32'h0; n_ifrd = 32'h0; n_drd = 32'h0;
      if (owner != 0) begin
        if (rdy || c == g + int'(MAX_WAIT) - 1) begin
          if (owner == 1) begin
            n_ifack = 1; n_iferr = !rdy; n_ifrd = rdy ? rdat : 32'h0;
          end else begin
            n_dack = 1; n_derr = !rdy; n_drd = (rdy && !dwe) ? ref_load(dfn, dad, rdat) : 32'h0;
          end
          owner = 0;
        end else begin
          n_valid = 1; n_busy = 1; n_addr = e_addr; n_we = e_we; n_strb = e_strb; n_wdata = e_wdata;
        end
      end else begin
        el_if = ifr && !e_ifack;
        el_d  = dr && !e_dack;
        if (el_d && (!el_if || !last_data)) begin
          last_data = 1'b1;
          if (ref_illegal(dwe, dfn, dad)) begin
            n_dack = 1; n_derr = 1;
          end else begin
            owner = 2; g = c + 1; n_valid = 1; n_busy = 1;
            n_addr = dad & ~32'h3; n_we = dwe;
            n_strb = dwe ? ref_strb(dfn, dad) : 4'h0;
            n_wdata = dwe ? ref_wdata(dfn, dwd) : 32'h0;
          end
        end else if (el_if) begin
          last_data = 1'b0; owner = 1; g = c + 1; n_valid = 1; n_busy = 1;
          n_addr = ifa & ~32'h3;
        end
      end
      e_valid = n_valid; e_we = n_we; e_busy = n_busy; e_ifack = n_ifack; e_iferr = n_iferr;
      e_dack = n_dack; e_derr = n_derr; e_strb = n_strb; e_addr = n_addr; e_wdata = n_wdata;
      e_ifrd = n_ifrd; e_drd = n_drd;
      step();
    end
    if_req = 1'b0; d_req = 1'b0; bus_ready = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'h80FF_0000, 0, 1'b0, 32'h100, 4'h0, 32'h0,        32'hFFFF_FF80};
    vt[1]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h80FF_0000, 1, 1'b0, 32'h100, 4'h0, 32'h0,        32'h0000_0080};
    vt[2]  = '{1'b1, 3'd1, 32'h206, 32'h1234_ABCD, 32'hFFFF_FFFF, 2, 1'b0, 32'h204, 4'hC, 32'hABCD_ABCD, 32'h0};
    vt[3]  = '{1'b0, 3'd2, 32'h102, 32'h0,        32'h0,         0, 1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
    vt[4]  = '{1'b1, 3'd3, 32'h400, 32'h0,        32'h0,         0, 1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
    vt[5]  = '{1'b1, 3'd0, 32'h301, 32'hAABB_CC55, 32'h0,        0, 1'b0, 32'h300, 4'h2, 32'h5555_5555, 32'h0};
    vt[6]  = '{1'b1, 3'd2, 32'h400, 32'hDEAD_BEEF, 32'h1234_5678, 3, 1'b0, 32'h400, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vt[7]  = '{1'b0, 3'd1, 32'h502, 32'h0,        32'h8001_7FFF, 1, 1'b0, 32'h500, 4'h0, 32'h0,        32'hFFFF_8001};
    vt[8]  = '{1'b0, 3'd5, 32'h500, 32'h0,        32'h8001_F00D, 0, 1'b0, 32'h500, 4'h0, 32'h0,        32'h0000_F00D};
    vt[9]  = '{1'b0, 3'd2, 32'h600, 32'h0,        32'hCAFE_F00D, 2, 1'b0, 32'h600, 4'h0, 32'h0,        32'hCAFE_F00D};
    vt[10] = '{1'b0, 3'd1, 32'h101, 32'h0,        32'h0,         0, 1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
    vt[11] = '{1'b0, 3'd6, 32'h700, 32'h0,        32'h0,         0, 1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
    vt[12] = '{1'b1, 3'd4, 32'h700, 32'h0,        32'h0,         0, 1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
    vt[13] = '{1'b0, 3'd0, 32'h100, 32'h0,        32'h1234_567F, 0, 1'b0, 32'h100, 4'h0, 32'h0,        32'h0000_007F};
    vt[14] = '{1'b1, 3'd1, 32'h200, 32'h0000_BEEF, 32'h0,        1, 1'b0, 32'h200, 4'h3, 32'hBEEF_BEEF, 32'h0};
    vt[15] = '{1'b1, 3'd0, 32'h203, 32'h0000_0012, 32'h0,        0, 1'b0, 32'h200, 4'h8, 32'h1212_1212, 32'h0};
    vt[16] = '{1'b0, 3'd0, 32'h702, 32'h0,        32'h00AB_0000, 3, 1'b0, 32'h700, 4'h0, 32'h0,        32'hFFFF_FFAB};

    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_func = 3'd0;
    d_addr = 32'h0; d_wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 17; i++) run_vec(i);

    // Fetch timeout: bus_valid for exactly MAX_WAIT cycles, then ack+err.
    if_req = 1'b1; if_addr = 32'h0000_1237;
    step();
    for (int k = 0; k < int'(MAX_WAIT); k++) begin
      chk("tmo bus_valid", 32'(bus_valid), 32'h1);
      chk("tmo bus_addr",  bus_addr,       32'h0000_1234);
      chk("tmo if_ack early", 32'(if_ack), 32'h0);
      step();
    end
    chk("tmo bus_valid drop", 32'(bus_valid), 32'h0);
    chk("tmo if_ack",   32'(if_ack), 32'h1);
    chk("tmo if_err",   32'(if_err), 32'h1);
    chk("tmo if_rdata", if_rdata,    32'h0);
    chk("tmo busy",     32'(busy),   32'h0);
    if_req = 1'b0;
    step();
    chk("tmo if_ack once", 32'(if_ack), 32'h0);
    chk("tmo idle valid",  32'(bus_valid), 32'h0);

    // Both requesters held from reset: grants alternate F,D,F,D.
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b0; d_func = 3'd2; d_addr = 32'h0000_0080;
    step();
    for (int gi = 0; gi < 4; gi++) begin
      chk("alt bus_valid", 32'(bus_valid), 32'h1);
      chk("alt bus_addr",  bus_addr, (gi % 2 == 0) ? 32'h40 : 32'h80);
      chk("alt no if_ack", 32'(if_ack), 32'h0);
      chk("alt no d_ack",  32'(d_ack),  32'h0);
      bus_ready = 1'b1; bus_rdata = 32'h1000 + 32'(gi);
      step();
      bus_ready = 1'b0;
      chk("alt if_ack", 32'(if_ack), (gi % 2 == 0) ? 32'h1 : 32'h0);
      chk("alt d_ack",  32'(d_ack),  (gi % 2 == 0) ? 32'h0 : 32'h1);
      if (gi % 2 == 0) chk("alt if_rdata", if_rdata, 32'h1000 + 32'(gi));
      else             chk("alt d_rdata",  d_rdata,  32'h1000 + 32'(gi));
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    step();

    // Reset during BUS_D, with bus_ready in the same cycle.
    d_req = 1'b1; d_we = 1'b0; d_func = 3'd2; d_addr = 32'h0000_0900;
    step();
    chk("rstmid bus_valid", 32'(bus_valid), 32'h1);
    step();
    rst = 1'b1; bus_ready = 1'b1; bus_rdata = 32'h5A5A_5A5A;
    step();
    rst = 1'b0; bus_ready = 1'b0; d_req = 1'b0;
    chk_all_zero("rstmid");
    step();
    chk("rstmid no d_ack",  32'(d_ack),     32'h0);
    chk("rstmid bus_valid", 32'(bus_valid), 32'h0);
    run_vec(0);

    do_reset();
    run_random(4000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
